// File: rtl/bresenham_line_drawer.sv
// Bresenham line rasteriser: takes two 10-bit endpoints and emits one pixel per
// accepted pix_valid/pix_ready beat, from (x0,y0) to (x1,y1) inclusive.
module bresenham_line_drawer (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       draw_en,
  input  logic [9:0] x0,
  input  logic [9:0] y0,
  input  logic [9:0] x1,
  input  logic [9:0] y1,
  input  logic       pix_ready,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       draw_done,
  output logic       busy,
  output logic [2:0] state
);

  // Handshake: a pixel transfers on a rising edge where pix_valid and pix_ready
  // are both high; pix_x/pix_y stay put while pix_valid is high and pix_ready is low.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SETUP     = 3'd1;
  localparam logic [2:0] ST_PLOT      = 3'd2;
  localparam logic [2:0] ST_DONE      = 3'd3;
  localparam logic [2:0] ST_DONE_WAIT = 3'd4;

  logic [9:0]         ex0, ey0, ex1, ey1;
  logic signed [11:0] dx, dy, err;
  logic               sx_neg, sy_neg;

  logic [9:0]         abs_x, abs_y;
  logic signed [11:0] setup_dx, setup_dy;
  logic signed [12:0] e2, dx_ext, dy_ext;
  logic               step_x, step_y;
  logic signed [11:0] err_next;
  logic [9:0]         next_x, next_y;
  logic               at_end;

  always_comb begin
    abs_x    = (ex1 >= ex0) ? (ex1 - ex0) : (ex0 - ex1);
    abs_y    = (ey1 >= ey0) ? (ey1 - ey0) : (ey0 - ey1);
    setup_dx = $signed({2'b00, abs_x});
    setup_dy = -$signed({2'b00, abs_y});
    // Both axis tests look at the same pre-step error term.
    e2       = {err, 1'b0};
    dx_ext   = dx;
    dy_ext   = dy;
    step_x   = (e2 >= dy_ext);
    step_y   = (e2 <= dx_ext);
    err_next = err + (step_x ? dy : 12'sd0) + (step_y ? dx : 12'sd0);
    next_x   = step_x ? (sx_neg ? pix_x - 10'd1 : pix_x + 10'd1) : pix_x;
    next_y   = step_y ? (sy_neg ? pix_y - 10'd1 : pix_y + 10'd1) : pix_y;
    at_end   = (pix_x == ex1) && (pix_y == ey1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= ST_IDLE;
      ex0    <= '0;
      ey0    <= '0;
      ex1    <= '0;
      ey1    <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
      pix_x  <= '0;
      pix_y  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (draw_en) begin
            ex0   <= x0;
            ey0   <= y0;
            ex1   <= x1;
            ey1   <= y1;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (!draw_en) begin
            state <= ST_IDLE;
          end else begin
            dx     <= setup_dx;
            dy     <= setup_dy;
            err    <= setup_dx + setup_dy;
            sx_neg <= !(ex0 < ex1);
            sy_neg <= !(ey0 < ey1);
            pix_x  <= ex0;
            pix_y  <= ey0;
            state  <= ST_PLOT;
          end
        end
        ST_PLOT: begin
          // Dropping draw_en abandons the line even on an accepted final pixel.
          if (!draw_en) begin
            state <= ST_IDLE;
          end else if (pix_ready) begin
            if (at_end) begin
              state <= ST_DONE;
            end else begin
              err   <= err_next;
              pix_x <= next_x;
              pix_y <= next_y;
            end
          end
        end
        ST_DONE: begin
          state <= ST_DONE_WAIT;
        end
        ST_DONE_WAIT: begin
          if (!draw_en) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign pix_valid = (state == ST_PLOT);
  assign draw_done = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_bresenham_line_drawer.sv
// Directed bench for bresenham_line_drawer: integer reference rasteriser feeding
// an expected-pixel queue, checked by a negedge monitor on every accepted beat.
module tb_bresenham_line_drawer;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SETUP     = 3'd1;
  localparam logic [2:0] ST_DONE_WAIT = 3'd4;

  logic       clk;
  logic       n_rst;
  logic       draw_en;
  logic [9:0] x0, y0, x1, y1;
  logic       pix_ready;
  logic       pix_valid;
  logic [9:0] pix_x, pix_y;
  logic       draw_done;
  logic       busy;
  logic [2:0] state;

  logic [19:0] exp_q[$];
  logic [19:0] model_q[$];
  logic [19:0] lit_q[$];

  int         tests = 0;
  int         fails = 0;
  int         done_count = 0;
  bit         prev_stall = 0;
  logic [19:0] prev_pix = '0;

  bresenham_line_drawer dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .draw_en   (draw_en),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .pix_ready (pix_ready),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .draw_done (draw_done),
    .busy      (busy),
    .state     (state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 400000");
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] pk(input int x, input int y);
    return {10'(x), 10'(y)};
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference rasteriser in plain integers; fills model_q.
  function automatic void model_gen(input int ax, input int ay, input int bx, input int by);
    int ddx, ddy, sx, sy, e, ee, x, y;
    model_q.delete();
    ddx = iabs(bx - ax);
    ddy = -iabs(by - ay);
    sx  = (ax < bx) ? 1 : -1;
    sy  = (ay < by) ? 1 : -1;
    e   = ddx + ddy;
    x   = ax;
    y   = ay;
    for (int guard = 0; guard < 2048; guard++) begin
      model_q.push_back(pk(x, y));
      if (x == bx && y == by) break;
      ee = 2 * e;
      if (ee >= ddy) begin e += ddy; x += sx; end
      if (ee <= ddx) begin e += ddx; y += sy; end
    end
  endfunction

  // Pins the reference model against a hand-written pixel list in lit_q.
  task automatic pin_model(input string name, input int ax, input int ay, input int bx, input int by);
    model_gen(ax, ay, bx, by);
    check({name, "_len"}, model_q.size(), lit_q.size());
    for (int i = 0; i < lit_q.size() && i < model_q.size(); i++)
      check({name, "_pix"}, model_q[i], lit_q[i]);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [19:0] e;
    if (!n_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && pix_valid)
        check("stall_hold", {pix_x, pix_y}, prev_pix);
      if (pix_valid && pix_ready) begin
        check("pixel_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pixel_value", {pix_x, pix_y}, e);
        end
      end
      if (draw_done) begin
        done_count++;
        check("done_after_last", exp_q.size(), 0);
        check("done_no_valid", pix_valid, 0);
      end
      prev_stall = pix_valid && !pix_ready;
      prev_pix   = {pix_x, pix_y};
    end
  end

  // ---------------- driver ----------------
  // Called #1 after a rising edge; returns #1 after a rising edge in IDLE.
  task automatic run_line(input int ax, input int ay, input int bx, input int by,
                          input int stall, input int hold);
    int plot_cyc, wc, cyc, d0, npix;
    bit done;
    plot_cyc = 0; wc = 0; cyc = 0; done = 0;
    model_gen(ax, ay, bx, by);
    npix = model_q.size();
    check("pixel_count", npix,
          ((iabs(bx - ax) > iabs(by - ay)) ? iabs(bx - ax) : iabs(by - ay)) + 1);
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    d0 = done_count;
    x0 = 10'(ax); y0 = 10'(ay); x1 = 10'(bx); y1 = 10'(by);
    draw_en   = 1'b1;
    pix_ready = 1'b0;
    @(posedge clk); #1;
    check("setup_state", state, ST_SETUP);
    check("setup_no_valid", pix_valid, 0);
    check("setup_busy", busy, 1);
    while (!done && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (draw_done) begin
        done = 1;
      end else if (pix_valid) begin
        if (plot_cyc == 0) check("first_pixel_latency", cyc, 1);
        plot_cyc++;
        if (wc < stall) begin pix_ready = 1'b0; wc++; end
        else begin pix_ready = 1'b1; wc = 0; end
      end
    end
    pix_ready = 1'b0;
    check("done_seen", done, 1);
    check("plot_cycles", plot_cyc, npix * (stall + 1));
    for (int i = 0; i <= hold; i++) begin
      @(posedge clk); #1;
      check("wait_state", state, ST_DONE_WAIT);
      check("wait_busy", busy, 1);
      check("wait_no_valid", pix_valid, 0);
      check("wait_no_done", draw_done, 0);
    end
    draw_en = 1'b0;
    @(posedge clk); #1;
    check("idle_state", state, ST_IDLE);
    check("idle_busy", busy, 0);
    check("one_done_pulse", done_count - d0, 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  // Starts (0,0)->(9,9) at full rate; returns #1 after the edge where the
  // third pixel (2,2) is presented.
  task automatic start_diag();
    model_gen(0, 0, 9, 9);
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    x0 = 10'd0; y0 = 10'd0; x1 = 10'd9; y1 = 10'd9;
    draw_en = 1'b1;
    pix_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("diag_third_pix", {pix_x, pix_y}, pk(2, 2));
  endtask

  // ---------------- stimulus ----------------
  int lines [8][4] = '{
    '{0, 5, 3, 0}, '{3, 0, 0, 5}, '{7, 1, 0, 4}, '{0, 4, 7, 1},
    '{9, 0, 0, 9}, '{0, 0, 0, 6}, '{6, 2, 1, 2}, '{1023, 1023, 0, 1020}
  };

  initial begin
    int d0;
    n_rst = 1'b0; draw_en = 1'b0; pix_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_state", state, ST_IDLE);
    check("rst_outputs", {pix_valid, draw_done, busy}, 0);
    check("rst_pix", {pix_x, pix_y}, 0);
    n_rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", state, ST_IDLE);

    // Hand-computed pixel lists pin the reference model.
    lit_q = '{pk(0,0), pk(1,1), pk(2,1), pk(3,2), pk(4,2)};
    pin_model("lit_0_0_4_2", 0, 0, 4, 2);
    lit_q = '{pk(2,2), pk(1,1), pk(0,0)};
    pin_model("lit_2_2_0_0", 2, 2, 0, 0);
    lit_q = '{pk(5,3)};
    pin_model("lit_degen", 5, 3, 5, 3);
    lit_q = '{pk(0,0), pk(1,0), pk(2,0), pk(3,0)};
    pin_model("lit_horiz", 0, 0, 3, 0);

    run_line(0, 0, 4, 2, 0, 0);
    run_line(2, 2, 0, 0, 0, 0);
    run_line(5, 3, 5, 3, 0, 0);
    run_line(0, 0, 3, 0, 2, 0);
    run_line(1, 3, 8, 6, 0, 3);
    foreach (lines[i]) run_line(lines[i][0], lines[i][1], lines[i][2], lines[i][3], 0, 0);

    // Abort after the second pixel has been accepted.
    d0 = done_count;
    start_diag();
    draw_en = 1'b0;
    @(posedge clk); #1;
    check("abort_no_valid", pix_valid, 0);
    check("abort_idle", state, ST_IDLE);
    check("abort_busy", busy, 0);
    check("abort_pix_retained", {pix_x, pix_y}, pk(2, 2));
    exp_q.delete();
    pix_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_no_done", done_count - d0, 0);
    run_line(1, 1, 1, 4, 0, 0);

    // Asynchronous reset between clock edges, mid-line.
    d0 = done_count;
    start_diag();
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_state", state, ST_IDLE);
    check("arst_outputs", {pix_valid, draw_done, busy}, 0);
    check("arst_pix", {pix_x, pix_y}, 0);
    draw_en = 1'b0;
    pix_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("arst_stays_idle", {state, pix_valid, draw_done}, {ST_IDLE, 2'b00});
    end
    check("arst_no_done", done_count - d0, 0);
    pix_ready = 1'b0;
    run_line(4, 9, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bresenham_line_drawer.md
BRESENHAM_LINE_DRAWER -- requirements
Module: bresenham_line_drawer

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port n_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have the port draw_en, input, 1 bit: level request from the Bresenham controller; held high until draw_done is seen.
REQ-004 The block SHALL have the ports x0, y0, x1, y1, input, 10 bits each, unsigned: line endpoints, sampled only on acceptance of draw_en.
REQ-005 The block SHALL have the port pix_ready, input, 1 bit: the downstream pixel writer accepts the current pixel.
REQ-006 The block SHALL have the port pix_valid, output, 1 bit: pix_x/pix_y hold a pixel to write.
REQ-007 The block SHALL have the ports pix_x, pix_y, output, 10 bits each: current pixel coordinate.
REQ-008 The block SHALL have the port draw_done, output, 1 bit: one-cycle pulse after the last pixel of the line is accepted.
REQ-009 The block SHALL have the port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-010 The block SHALL implement the states IDLE, SETUP, PLOT, DONE and DONE_WAIT.
REQ-011 In IDLE, when draw_en=1, the block SHALL latch x0, y0, x1 and y1 and go to SETUP; otherwise it SHALL stay in IDLE.
REQ-012 In SETUP (one cycle), the block SHALL compute dx=|x1-x0|, dy=-|y1-y0|, sx=+1 if x0<x1 else -1, sy=+1 if y0<y1 else -1, err=dx+dy, set cur=(x0,y0), and go to PLOT.
REQ-013 err SHALL be 12-bit two's complement and e2=2*err SHALL be 13-bit two's complement; no overflow is possible for 10-bit coordinates.
REQ-014 In PLOT, the block SHALL assert pix_valid=1 with pix_x/pix_y equal to cur, and cur SHALL hold stable while pix_ready=0.
REQ-015 In PLOT, when pix_ready=1 and cur=(x1,y1), the block SHALL go to DONE.
REQ-016 In PLOT, when pix_ready=1 and cur!=(x1,y1), the block SHALL step using pre-step err: if e2>=dy then err+=dy and x+=sx; if e2<=dx then err+=dx and y+=sy; both tests SHALL use the same e2.
REQ-017 Pixel ordering SHALL be from (x0,y0) to (x1,y1) inclusive, with pixel count max(dx,-dy)+1.
REQ-018 Latency: for draw_en accepted in IDLE at edge N, the first pix_valid SHALL appear in the cycle after edge N+1; with pix_ready held high, one pixel SHALL be emitted per cycle.
REQ-019 In DONE, the block SHALL assert draw_done=1 for exactly one cycle and go to DONE_WAIT.
REQ-020 In DONE_WAIT, the block SHALL go to IDLE when draw_en=0 and stay while draw_en=1, so that a still-high draw_en never restarts the same line.
REQ-021 If draw_en=0 in SETUP or PLOT (abort), the block SHALL go to IDLE next cycle with no draw_done pulse, and pix_valid SHALL drop in that next cycle.
REQ-022 A degenerate line (x0=x1 and y0=y1) SHALL emit exactly one pixel, then draw_done.
REQ-023 pix_valid SHALL be 0 outside PLOT, and draw_done SHALL be 0 outside DONE.
REQ-024 pix_x and pix_y SHALL retain their last value outside PLOT.
REQ-025 Horizontal, vertical, diagonal and all eight octants SHALL be handled with no special case beyond REQ-016.

Reset
REQ-026 On n_rst=0, regardless of clk, the block SHALL set state=IDLE, pix_valid=0, draw_done=0, busy=0, pix_x=0, pix_y=0, err=0, and clear the latched endpoints.
REQ-027 A reset asserted mid-line SHALL abandon the line; after release, the block SHALL wait for draw_en in IDLE and SHALL emit no pixel or draw_done from the old line.

Verification
REQ-028 The bench SHALL cover: (0,0)->(4,2), pix_ready=1 -> pixels (0,0),(1,1),(2,1),(3,2),(4,2) on consecutive cycles, then one draw_done pulse.
REQ-029 The bench SHALL cover: (2,2)->(0,0) -> pixels (2,2),(1,1),(0,0), then draw_done; (5,3)->(5,3) -> single pixel (5,3), then draw_done.
REQ-030 The bench SHALL cover: (0,0)->(3,0) with pix_ready low 2 cycles on each pixel -> 4 pixels (0..3,0), each held stable while stalled, and draw_done only after (3,0) is accepted.
REQ-031 The bench SHALL cover: draw_en held high 3 cycles after draw_done -> block stays in DONE_WAIT with busy=1 and no new pix_valid; draw_en low -> IDLE, busy=0.
REQ-032 The bench SHALL cover: draw_en dropped after the 2nd pixel of (0,0)->(9,9) -> pix_valid=0 next cycle, no draw_done; a new request (1,1)->(1,4) then draws (1,1)..(1,4) correctly.
REQ-033 The bench SHALL cover: n_rst pulsed low mid-line, asynchronously between clock edges -> all outputs 0 immediately and state=IDLE.
